c3aibadapt_rx_avmm_csr: RTL
===========================

Name: c3aibadapt_rx_avmm_csr

Overview:
- AVMM slave register file directly upstream of the RX DPRIO configuration stage.
- Decodes 8-bit AVMM read/write transactions into a flat bank of RX configuration bytes; that bank drives the RX datapath, async and clock-control config fields.
- Returns user-readable status (datapath user datain, async user datain, user clock config) as read-only registers.
- Single clock domain: the AVMM/config clock.

Parameters:
- ADDR_W, 6, width of the AVMM address bus.
- NUM_CFG, 16, number of RW configuration bytes, at offsets 0x00..NUM_CFG-1. Legal range 1..32.
- RD_LAT, 2, number of wait cycles inserted before read data is returned. Legal range 1..4.
- CFG_RST_VAL, {8*NUM_CFG{1'b0}}, reset value of the flat config bank. Byte i sits at bits [8i+7:8i].

Ports:
- avmm_clk  in  1  config/AVMM clock.
- avmm_rst_n  in  1  asynchronous active-low reset.
- avmm_write  in  1  write request.
- avmm_read  in  1  read request; master holds it while avmm_waitreq=1.
- avmm_addr  in  ADDR_W  byte address.
- avmm_wdata  in  8  write data.
- avmm_rdata  out  8  read data, valid when avmm_rdatavld=1.
- avmm_rdatavld  out  1  one-cycle read-data-valid pulse.
- avmm_waitreq  out  1  stall for reads.
- rx_cfg_out  out  8*NUM_CFG  flat config bank feeding RX DPRIO.
- dp_user_datain  in  16  RO status, at offsets 0x20 (bits [7:0]) and 0x21 (bits [15:8]).
- async_user_datain  in  24  RO status, at offsets 0x22..0x24, LSB first.
- user_clk_config  in  16  RO status, at offsets 0x25..0x26, LSB first.

Interface (already decided): one clock, avmm_clk; reset avmm_rst_n is asynchronous and active-low.

Behaviour:
- Reset values: rx_cfg_out = CFG_RST_VAL, avmm_rdata = 0x00, avmm_rdatavld = 0, FSM in IDLE, wait counter = 0.
- FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE with avmm_write=1:
  - Offsets < NUM_CFG: byte is updated at the next edge; 1-cycle write, avmm_waitreq=0.
  - Offsets >= NUM_CFG (including RO offsets): write is ignored; the cycle is still accepted.
- IDLE with avmm_read=1 and avmm_write=0:
  - Capture avmm_addr, load counter with RD_LAT-1, go to RD_WAIT.
- RD_WAIT:
  - Counter decrements each cycle.
  - When counter == 0: register the decoded data into avmm_rdata and go to RD_DONE.
- RD_DONE:
  - avmm_rdatavld = 1 for exactly one cycle; avmm_rdata holds its value until the next read.
  - Return to IDLE.
- avmm_waitreq (combinational) = avmm_read & (state != RD_DONE). Every read therefore stalls RD_LAT+1 cycles and is accepted in the RD_DONE cycle. Issue-to-data latency is RD_LAT+1 cycles.
- Read decode: status ports are sampled at the counter==0 edge, not at issue time. Unmapped offsets, including NUM_CFG..0x1F and >= 0x27, read 0x00.
- Simultaneous avmm_read=1 and avmm_write=1 in IDLE: the write executes, the read is dropped, and no rdatavld is produced.
- Writes presented while not in IDLE are ignored.
- A write to a config byte during an in-flight read to the same byte cannot occur, because a write is only accepted in IDLE.
- Async reset asserted mid-read: FSM returns to IDLE immediately, avmm_rdatavld=0 and avmm_rdata=0x00. The in-flight read is lost; the master re-issues it.
- Address compare uses the full ADDR_W bits; there is no aliasing.

Optional Feature:
- Macro: C3AIBADAPT_RX_CSR_PARITY_EN.
- Enabled:
  - Each config byte carries a hidden even-parity bit, written together with the byte.
  - Continuous check; any mismatch sets sticky output csr_parity_err (1 bit, reset 0).
  - Offset 0x27 reads {7'b0, csr_parity_err}. Writing 0x01 to 0x27 clears the flag; a same-cycle new mismatch takes priority over the clear.
- Disabled: no parity storage, no csr_parity_err port, and offset 0x27 reads 0x00.

Test Plan:
- Reset with CFG_RST_VAL byte3=0xA5 -> rx_cfg_out[31:24]=0xA5, avmm_rdatavld=0, avmm_waitreq=0 while idle.
- Write 0x3C to 0x05, then read 0x05 with RD_LAT=2 -> waitreq high 3 cycles; rdatavld pulses on cycle 3 after issue with rdata=0x3C; rx_cfg_out[47:40]=0x3C from the edge after the write.
- dp_user_datain=0xBEEF, read 0x20 then 0x21 -> 0xEF, then 0xBE. async_user_datain=0x123456, read 0x24 -> 0x12.
- Write 0x77 to 0x22 (RO) and to 0x1F (unmapped) -> no rx_cfg_out change; reading either of them returns the status byte and 0x00 respectively.
- read=write=1 to 0x02 with wdata 0x9C -> byte2=0x9C, no rdatavld, FSM stays in IDLE.
- Assert avmm_rst_n=0 during RD_WAIT -> rdatavld never pulses, rdata=0x00 and rx_cfg_out=CFG_RST_VAL. With parity enabled, force a config bit flip -> csr_parity_err=1; write 0x01 to 0x27 -> flag clears.

Source files
------------

// File: rtl/c3aibadapt_rx_avmm_csr_if.sv
// AVMM 8-bit slave bus between the config master and the RX CSR bank.
// Reads stall on avmm_waitreq and return data on a one-cycle avmm_rdatavld pulse.
interface c3aibadapt_rx_avmm_csr_if #(
    parameter int ADDR_W = 6
);
    logic              avmm_write;
    logic              avmm_read;
    logic [ADDR_W-1:0] avmm_addr;
    logic [7:0]        avmm_wdata;
    logic [7:0]        avmm_rdata;
    logic              avmm_rdatavld;
    logic              avmm_waitreq;

    modport master (
        output avmm_write, avmm_read, avmm_addr, avmm_wdata,
        input  avmm_rdata, avmm_rdatavld, avmm_waitreq
    );

    modport slave (
        input  avmm_write, avmm_read, avmm_addr, avmm_wdata,
        output avmm_rdata, avmm_rdatavld, avmm_waitreq
    );
endinterface

// File: rtl/c3aibadapt_rx_avmm_csr.sv
// RX AVMM CSR bank: RW config bytes feeding RX DPRIO plus RO user status.
// Optional hidden per-byte parity enabled by C3AIBADAPT_RX_CSR_PARITY_EN.
module c3aibadapt_rx_avmm_csr #(
    parameter int                   ADDR_W      = 6,
    parameter int                   NUM_CFG     = 16,
    parameter int                   RD_LAT      = 2,
    parameter logic [8*NUM_CFG-1:0] CFG_RST_VAL = '0
) (
    input  logic                         avmm_clk,
    input  logic                         avmm_rst_n,
    c3aibadapt_rx_avmm_csr_if.slave      avmm,
    output logic [8*NUM_CFG-1:0]         rx_cfg_out,
    input  logic [15:0]                  dp_user_datain,
    input  logic [23:0]                  async_user_datain,
`ifdef C3AIBADAPT_RX_CSR_PARITY_EN
    input  logic [15:0]                  user_clk_config,
    output logic                         csr_parity_err
`else
    input  logic [15:0]                  user_clk_config
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [8*NUM_CFG-1:0] cfg_q;
    logic [7:0]          rd_mux;
    logic                wr_en;

    assign wr_en = (state_q == IDLE) && avmm.avmm_write;

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (avmm.avmm_read && !avmm.avmm_write) begin
                    addr_d  = avmm.avmm_addr;
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = rd_mux;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            cfg_q <= CFG_RST_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (avmm.avmm_addr == ADDR_W'(i))
                    cfg_q[8*i +: 8] <= avmm.avmm_wdata;
            end
        end
    end

`ifdef C3AIBADAPT_RX_CSR_PARITY_EN
    logic [NUM_CFG-1:0] par_q;
    logic               par_mis;
    logic               perr_clr;
    logic               perr_q;

    // Stored parity is compared against the live byte every cycle.
    always_comb begin
        par_mis = 1'b0;
        for (int i = 0; i < NUM_CFG; i++)
            par_mis = par_mis | ((^cfg_q[8*i +: 8]) != par_q[i]);
    end

    assign perr_clr = wr_en && (avmm.avmm_addr == ADDR_W'('h27)) &&
                      (avmm.avmm_wdata == 8'h01);

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            for (int i = 0; i < NUM_CFG; i++)
                par_q[i] <= ^CFG_RST_VAL[8*i +: 8];
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (avmm.avmm_addr == ADDR_W'(i))
                    par_q[i] <= ^avmm.avmm_wdata;
            end
        end
    end

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n)
            perr_q <= 1'b0;
        else
            perr_q <= par_mis | (perr_q & ~perr_clr);
    end

    assign csr_parity_err = perr_q;
`endif

    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (addr_q == ADDR_W'(i))
                rd_mux = cfg_q[8*i +: 8];
        end
        case (addr_q)
            ADDR_W'('h20): rd_mux = dp_user_datain[7:0];
            ADDR_W'('h21): rd_mux = dp_user_datain[15:8];
            ADDR_W'('h22): rd_mux = async_user_datain[7:0];
            ADDR_W'('h23): rd_mux = async_user_datain[15:8];
            ADDR_W'('h24): rd_mux = async_user_datain[23:16];
            ADDR_W'('h25): rd_mux = user_clk_config[7:0];
            ADDR_W'('h26): rd_mux = user_clk_config[15:8];
`ifdef C3AIBADAPT_RX_CSR_PARITY_EN
            ADDR_W'('h27): rd_mux = {7'b0, perr_q};
`endif
            default: ;
        endcase
    end

    assign avmm.avmm_rdata    = rdata_q;
    assign avmm.avmm_rdatavld = (state_q == RD_DONE);
    assign avmm.avmm_waitreq  = avmm.avmm_read && (state_q != RD_DONE);
    assign rx_cfg_out         = cfg_q;

endmodule
